// File: rtl/blackjack_pkg.sv
// Shared constants, FSM state encoding and the blackjack value helper for the
// card dealer.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int SUIT_SIZE = 13;

  localparam logic [3:0] RANK_A = 4'd1;
  localparam logic [3:0] RANK_J = 4'd11;
  localparam logic [3:0] RANK_Q = 4'd12;
  localparam logic [3:0] RANK_K = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ace counts as 1 here; the game FSM decides when it is soft.
  function automatic logic [3:0] bj_value(input logic [3:0] rank);
    if (rank == RANK_A) return 4'd1;
    if (rank == RANK_J || rank == RANK_Q || rank == RANK_K) return 4'd10;
    return rank;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Ports:
//   clk    - clock, steps on every rising edge
//   resetn - async active-low reset, loads SEED
//   q      - current LFSR state (never zero when SEED is nonzero)
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // Right-shifting Galois form: the bit shifted out folds back into the tap mask.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_q <= SEED;
    else         r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? 16'hB400 : 16'h0000);
  end

  assign q = r_q;

endmodule

// File: rtl/card_dealer.sv
// Card source for the blackjack game FSM. Deals cards without replacement from a
// single deck: an LFSR picks a starting slot, a used-card bitmap is probed
// linearly until a free slot is found, and the slot is mapped to rank/suit/value.
// Ports:
//   CLOCK_50   - system clock
//   resetn     - async active-low reset
//   shuffle    - pulse: refill the deck and abort any draw in progress
//   draw_req   - pulse: request a card (dropped while busy or deck empty)
//   card_valid - pulse: card_rank/suit/value carry a new card
//   card_rank  - 1=A .. 13=K, held between cards
//   card_suit  - 0..3, held
//   card_value - blackjack value, A=1, faces=10, held
//   cards_left - cards remaining, 0..52
//   busy       - FSM not idle
//   deck_empty - cards_left == 0
module card_dealer #(
  parameter int          DECK_SIZE  = blackjack_pkg::DECK_SIZE,
  parameter int          LFSR_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       busy,
  output logic       deck_empty
);
  import blackjack_pkg::*;

  state_t                  r_state, w_state_nxt;
  logic [DECK_SIZE-1:0]    r_used;
  logic [5:0]              r_idx;
  logic [5:0]              r_cards_left;
  logic                    r_valid;
  logic [3:0]              r_rank, r_value;
  logic [1:0]              r_suit;

  logic [LFSR_WIDTH-1:0]   w_lfsr;
  logic [5:0]              w_pick_idx, w_idx_inc, w_base;
  logic                    w_hit_used;
  logic [1:0]              w_suit;
  logic [3:0]              w_rank;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .q      (w_lfsr)
  );

  // 6 LFSR bits cover 0..63; fold the top 12 back into the deck.
  assign w_pick_idx = (w_lfsr[5:0] >= 6'(DECK_SIZE)) ? w_lfsr[5:0] - 6'(DECK_SIZE)
                                                      : w_lfsr[5:0];
  assign w_idx_inc  = (r_idx == 6'(DECK_SIZE - 1)) ? 6'd0 : r_idx + 6'd1;
  assign w_hit_used = r_used[r_idx];

  // Slot to suit by three compares, rank is the offset within the suit.
  always_comb begin
    w_suit = 2'd0;
    w_base = 6'd0;
    if (r_idx >= 6'(3*SUIT_SIZE)) begin
      w_suit = 2'd3; w_base = 6'(3*SUIT_SIZE);
    end else if (r_idx >= 6'(2*SUIT_SIZE)) begin
      w_suit = 2'd2; w_base = 6'(2*SUIT_SIZE);
    end else if (r_idx >= 6'(SUIT_SIZE)) begin
      w_suit = 2'd1; w_base = 6'(SUIT_SIZE);
    end
    w_rank = 4'(r_idx - w_base) + 4'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (draw_req && !deck_empty) w_state_nxt = PICK;
      PICK:    w_state_nxt = PROBE;
      PROBE:   if (!w_hit_used) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (shuffle) w_state_nxt = IDLE;
  end

  // The card registers load on the PROBE->DONE edge so that they are already
  // stable during the DONE cycle, the same cycle card_valid is high.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_used       <= '0;
      r_idx        <= '0;
      r_cards_left <= 6'(DECK_SIZE);
      r_valid      <= 1'b0;
      r_rank       <= '0;
      r_suit       <= '0;
      r_value      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (shuffle) begin
        r_used       <= '0;
        r_cards_left <= 6'(DECK_SIZE);
      end else begin
        case (r_state)
          PICK: r_idx <= w_pick_idx;
          PROBE: begin
            if (w_hit_used) begin
              r_idx <= w_idx_inc;
            end else begin
              r_used[r_idx] <= 1'b1;
              r_cards_left  <= r_cards_left - 6'd1;
              r_rank        <= w_rank;
              r_suit        <= w_suit;
              r_value       <= bj_value(w_rank);
              r_valid       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign card_valid = r_valid;
  assign card_rank  = r_rank;
  assign card_suit  = r_suit;
  assign card_value = r_value;
  assign cards_left = r_cards_left;
  assign busy       = (r_state != IDLE);
  assign deck_empty = (r_cards_left == 6'd0);

  // A zero LFSR state would lock up and bias every pick to slot 0.
  a_lfsr_nonzero: assert property (@(posedge CLOCK_50) disable iff (!resetn)
                                   w_lfsr != '0);

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       resetn, shuffle, draw_req;
  logic       card_valid, busy, deck_empty;
  logic [3:0] card_rank, card_value;
  logic [1:0] card_suit;
  logic [5:0] cards_left;

  always #5 clk = ~clk;

  card_dealer dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .shuffle    (shuffle),
    .draw_req   (draw_req),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_suit  (card_suit),
    .card_value (card_value),
    .cards_left (cards_left),
    .busy       (busy),
    .deck_empty (deck_empty)
  );

  typedef struct {
    int rank;
    int suit;
    int value;
    int left;
  } card_t;

  card_t exp_q[$];
  card_t last_card, card1;
  int    tests = 0, fails = 0;
  int    n_valid = 0;
  int    last_k = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  bit          used_m[52];
  int          left_m;

  // Deck statistics for the full-deal scenario
  bit seen[4][16];
  int n_distinct = 0;
  int suit_cnt[4];
  int val1_cnt = 0, val7_cnt = 0, val10_cnt = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  always @(posedge clk or negedge resetn)
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= lfsr_step(m_lfsr);

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    foreach (used_m[i]) used_m[i] = 1'b0;
    left_m = 52;
    exp_q.delete();
  endtask

  task automatic model_shuffle();
    foreach (used_m[i]) used_m[i] = 1'b0;
    left_m = 52;
  endtask

  // Called in the PICK cycle, when m_lfsr equals the value the dealer samples.
  task automatic model_draw();
    int v;
    int k;
    int r;
    v = int'(m_lfsr[5:0]);
    if (v >= 52) v -= 52;
    k = 0;
    while (used_m[v]) begin
      v = (v + 1) % 52;
      k++;
    end
    used_m[v] = 1'b1;
    left_m--;
    r = v % 13 + 1;
    exp_q.push_back('{r, v / 13, (r >= 10) ? 10 : r, left_m});
    last_k = k;
  endtask

  task automatic do_draw();
    @(negedge clk); draw_req = 1'b1;
    @(posedge clk); #1; model_draw();
    @(negedge clk); draw_req = 1'b0;
  endtask

  // skew: posedges after the accepting edge already consumed by the caller.
  task automatic wait_card(input string name, input int skew);
    int n0;
    int c;
    n0 = n_valid;
    c  = 0;
    while (n_valid == n0 && c < 60) begin
      @(posedge clk);
      c++;
    end
    if (n_valid == n0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no card_valid within 60 cycles", name);
    end else begin
      check({name, "_latency"}, c + skew, 3 + last_k);
    end
  endtask

  task automatic release_and_first_draw();
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(negedge clk);
    do_draw();
  endtask

  task automatic record(input card_t c);
    if (c.suit >= 0 && c.suit < 4 && c.rank >= 0 && c.rank < 16) begin
      if (!seen[c.suit][c.rank]) n_distinct++;
      seen[c.suit][c.rank] = 1'b1;
      suit_cnt[c.suit]++;
    end
    if (c.rank == 1 && c.value == 1)  val1_cnt++;
    if (c.rank == 7 && c.value == 7)  val7_cnt++;
    if (c.rank >= 10 && c.value == 10) val10_cnt++;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    card_t e;
    if (resetn === 1'b1 && card_valid === 1'b1) begin
      n_valid++;
      last_card = '{int'(card_rank), int'(card_suit), int'(card_value), int'(cards_left)};
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_card: rank %0d suit %0d, expected no card", card_rank, card_suit);
      end else begin
        e = exp_q.pop_front();
        check("card_rank",  int'(card_rank),  e.rank);
        check("card_suit",  int'(card_suit),  e.suit);
        check("card_value", int'(card_value), e.value);
        check("cards_left", int'(cards_left), e.left);
        check("deck_empty", int'(deck_empty), (e.left == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int busy_cnt;
    resetn = 1'b0; shuffle = 1'b0; draw_req = 1'b0;
    foreach (suit_cnt[i]) suit_cnt[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_card_valid", int'(card_valid), 0);
    check("rst_card_rank",  int'(card_rank),  0);
    check("rst_card_suit",  int'(card_suit),  0);
    check("rst_card_value", int'(card_value), 0);
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_busy",       int'(busy),       0);
    check("rst_deck_empty", int'(deck_empty), 0);

    // Scenario 1: first card after reset
    release_and_first_draw();
    wait_card("s1", 0);
    card1 = last_card;
    record(card1);
    repeat (5) @(negedge clk);
    check("s1_valid_once", n_valid, 1);
    check("s1_cards_left", int'(cards_left), 51);

    // Scenario 2/4: deal the rest of the deck
    for (int i = 0; i < 51; i++) begin
      do_draw();
      wait_card("s2", 0);
      record(last_card);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    check("s2_distinct",   n_distinct, 52);
    check("s2_cards_left", int'(cards_left), 0);
    check("s2_deck_empty", int'(deck_empty), 1);
    for (int s = 0; s < 4; s++) check("s4_suit_count", suit_cnt[s], 13);
    check("s4_ace_value1",  val1_cnt,  4);
    check("s4_seven_value", val7_cnt,  4);
    check("s4_face_value",  val10_cnt, 16);

    // Scenario 3: draw on an empty deck is ignored
    n0 = n_valid;
    busy_cnt = 0;
    @(negedge clk); draw_req = 1'b1;
    @(negedge clk); draw_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cnt++;
    end
    check("s3_no_card", n_valid - n0, 0);
    check("s3_busy_low", busy_cnt, 0);
    @(negedge clk); shuffle = 1'b1;
    @(negedge clk); shuffle = 1'b0;
    model_shuffle();
    check("s3_shuffle_left",  int'(cards_left), 52);
    check("s3_shuffle_empty", int'(deck_empty), 0);

    // Scenario 5: second request while busy is dropped
    n0 = n_valid;
    @(negedge clk); draw_req = 1'b1;
    @(posedge clk); #1; model_draw();
    @(negedge clk);
    @(negedge clk); draw_req = 1'b0;
    wait_card("s5", 1);
    repeat (5) @(negedge clk);
    check("s5_valid_once", n_valid - n0, 1);
    check("s5_cards_left", int'(cards_left), 51);

    // shuffle and draw_req together: shuffle wins
    n0 = n_valid;
    @(negedge clk); shuffle = 1'b1; draw_req = 1'b1;
    @(negedge clk); shuffle = 1'b0; draw_req = 1'b0;
    model_shuffle();
    repeat (60) @(negedge clk);
    check("s5_shuf_no_card", n_valid - n0, 0);
    check("s5_shuf_left",    int'(cards_left), 52);

    // Scenario 6: reset during PROBE
    @(negedge clk); draw_req = 1'b1;
    @(posedge clk); #1; model_draw();
    @(negedge clk); draw_req = 1'b0;
    @(negedge clk);
    check("s6_busy_in_probe", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check("s6_rst_valid", int'(card_valid), 0);
    check("s6_rst_rank",  int'(card_rank),  0);
    check("s6_rst_suit",  int'(card_suit),  0);
    check("s6_rst_value", int'(card_value), 0);
    check("s6_rst_left",  int'(cards_left), 52);
    check("s6_rst_busy",  int'(busy),       0);
    model_reset();
    n0 = n_valid;
    @(negedge clk);
    release_and_first_draw();
    wait_card("s6", 0);
    repeat (5) @(negedge clk);
    check("s6_valid_once", n_valid - n0, 1);
    check("s6_same_rank", last_card.rank, card1.rank);
    check("s6_same_suit", last_card.suit, card1.suit);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
